// File: rtl/div_pkg.sv
// Shared constants and types for the iterative signed divider.
package div_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int ITER_COUNT = DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;
endpackage

// File: rtl/div_if.sv
// Request/result bundle between the issuing stage and the divider.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                    start;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic signed [WIDTH-1:0] hi_out;
    logic signed [WIDTH-1:0] lo_out;
    logic                    busy;
    logic                    done;
    logic                    div_zero;

    modport master (
        output start, dividend, divisor,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < dvs, so a non-borrowing difference always fits in WIDTH bits
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: magnitudes iterate one bit per clock, signs are
// restored in a single negate stage when the result is written.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             busy;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (quo_q[WIDTH-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.divisor == '0) ? FINISH : RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // quo_q doubles as the dividend shift register: its MSB feeds each step
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_d      = magnitude(bus.dividend);
                    dvs_d      = magnitude(bus.divisor);
                    neg_quo_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d  = bus.dividend[WIDTH-1];
                    zero_d     = (bus.divisor == '0);
                    div_zero_d = 1'b0;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
            end
            FINISH: begin
                done_d = 1'b1;
                if (zero_q) begin
                    div_zero_d = 1'b1;
                end else begin
                    lo_d = neg_quo_q ? -quo_q : quo_q;
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a division; sampled only while the unit is idle.
REQ-005 dividend  input  WIDTH  signed two's-complement dividend (register-file A operand).
REQ-006 divisor  input  WIDTH  signed two's-complement divisor (register-file B operand).
REQ-007 hi_out  output  WIDTH  remainder; feeds a data input of the downstream write-back mux.
REQ-008 lo_out  output  WIDTH  quotient; feeds a data input of the downstream write-back mux.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse marking that hi_out/lo_out/div_zero are updated.
REQ-011 div_zero  output  1  last completed request had divisor == 0.

Function
REQ-012 The state machine SHALL have states IDLE, RUN and FINISH, and SHALL leave IDLE only when start=1.
REQ-013 Start accepted at edge k (IDLE) with divisor != 0: latch |dividend|, |divisor| and both signs, clear the iteration counter, clear div_zero, enter RUN; busy=1 from edge k.
REQ-014 RUN SHALL perform one restoring shift-subtract iteration per clock, exactly WIDTH iterations (edges k+1..k+32), then enter FINISH.
REQ-015 At edge k+33 (FINISH): lo_out = quotient and hi_out = remainder with signs applied; done=1 for exactly one cycle; busy=0; return to IDLE.
REQ-016 Quotient SHALL truncate toward zero; the remainder SHALL take the dividend's sign (nonzero remainder) and satisfy |hi| < |divisor|.
REQ-017 0x80000000 / 0xFFFFFFFF SHALL yield lo_out=0x80000000 and hi_out=0 (wrap-around, no flag).
REQ-018 Start accepted with divisor == 0: skip RUN and enter FINISH at edge k; at edge k+1 assert done=1 and div_zero=1, keep hi_out/lo_out unchanged.
REQ-019 div_zero SHALL hold its value until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored; operand changes during RUN SHALL not affect the result.
REQ-021 hi_out/lo_out SHALL change only at a FINISH edge or at reset, and SHALL hold between operations.
REQ-022 A start asserted in the cycle where done=1 SHALL be accepted (back-to-back operation).

Reset
REQ-023 reset=0 SHALL, asynchronously and at any state including mid-RUN, force IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, and clear the counter and internal operand registers.
REQ-024 After reset deassertion, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-025 Package div_pkg SHALL hold the WIDTH default, the state enum (IDLE, RUN, FINISH) and the iteration count constant.
REQ-026 One combinational sub-module div_step SHALL implement a single shift-subtract iteration (partial remainder, quotient bit); div_unit SHALL instantiate it once.
REQ-027 Sign correction SHALL be a single negate stage in FINISH, not inside the iteration loop.

Verification
REQ-028 100 / 7, start at edge k -> done only at k+33, lo_out=14, hi_out=2, div_zero=0.
REQ-029 -100 / 7 -> lo_out=0xFFFFFFF2, hi_out=0xFFFFFFFE; 100 / -7 -> lo_out=0xFFFFFFF2, hi_out=2.
REQ-030 Prior result loaded, then 5 / 0 -> done at k+1, div_zero=1, hi_out/lo_out unchanged; next valid start clears div_zero.
REQ-031 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0 after 33 cycles.
REQ-032 reset=0 at cycle 10 of RUN -> all outputs 0 immediately; 9 / 3 after release -> lo_out=3, hi_out=0.
REQ-033 start pulsed with new operands at cycles 5 and 20 of RUN -> ignored, original result returned; start during done cycle -> accepted, busy=1 next cycle.
